// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per cycle.
// Latency: out_valid rises WIDTH clk edges after the edge that accepts bin.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// Optional macro BIN2BCD_SEVSEG_EN adds a registered active-low 7-segment port.
module bin2bcd_seq #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BIN2BCD_SEVSEG_EN
  ,
  output logic [7*DIGITS-1:0]   seg
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_BIN = (64'd1 << WIDTH) - 64'd1;

  // The digit count must cover the largest input value.
  generate
    if (pow10(DIGITS) <= MAX_BIN) begin : g_range_err
      $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [SW-1:0]   scratch;
  logic [WIDTH-1:0] bin_shift;
  logic [CW-1:0]   cnt;

  logic [SW-1:0]       adj;
  logic [SW+WIDTH-1:0] cat_sh;
  logic [SW-1:0]       scratch_nxt;
  logic [WIDTH-1:0]    bin_nxt;

  // One double-dabble step: add 3 to digits >= 5, then shift scratch:bin left.
  always_comb begin
    adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
    cat_sh = {adj, bin_shift} << 1;
  end

  assign scratch_nxt = cat_sh[SW+WIDTH-1:WIDTH];
  assign bin_nxt     = cat_sh[WIDTH-1:0];

`ifdef BIN2BCD_SEVSEG_EN
  // Active-low segments ordered {g,f,e,d,c,b,a}; non-decimal codes blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [7*DIGITS-1:0] seg_nxt;

  // Decode the final scratch value so seg loads on the same edge as bcd.
  always_comb begin
    seg_nxt = '0;
    for (int d = 0; d < DIGITS; d++) seg_nxt[7*d +: 7] = seg7(scratch_nxt[4*d +: 4]);
  end
`else
  // Plain build: no segment decode, bcd is the only result port.
`endif

  // Control FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      scratch   <= '0;
      bin_shift <= '0;
      cnt       <= '0;
      bcd       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef BIN2BCD_SEVSEG_EN
      seg       <= {DIGITS{7'b1000000}};
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_shift <= bin;
            scratch   <= '0;
            cnt       <= CW'(WIDTH);
            in_ready  <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          scratch   <= scratch_nxt;
          bin_shift <= bin_nxt;
          cnt       <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd       <= scratch_nxt;
`ifdef BIN2BCD_SEVSEG_EN
            seg       <= seg_nxt;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner cases plus random values.
// Reference digits come from decimal division of the input value.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_bin2bcd_seq;
  localparam int WIDTH  = 12;
  localparam int DIGITS = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     bin = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [4*DIGITS-1:0]  bcd;
`ifdef BIN2BCD_SEVSEG_EN
  logic [7*DIGITS-1:0]  seg;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd)
`ifdef BIN2BCD_SEVSEG_EN
    ,
    .seg       (seg)
`endif
  );

  // Decimal digits of v, units in the low nibble.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after an accepting edge until out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // Full transaction: accept v, check latency and digits, stall, then release.
  task automatic convert(input int v, input int stall, input string tag);
    int lat;
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    bin = WIDTH'(v);
    tick();
    in_valid = 1'b0;
    check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
    wait_valid(lat);
    check({tag, " latency"}, 32'(lat), 32'd12);
    check({tag, " bcd"}, 32'(bcd), 32'(ref_bcd(v)));
    for (int s = 0; s < stall; s++) begin
      tick();
      check({tag, " stall valid"}, 32'(out_valid), 32'd1);
      check({tag, " stall bcd"}, 32'(bcd), 32'(ref_bcd(v)));
      check({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " released"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int bad;
    int hi;
    int v;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset bcd", 32'(bcd), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post-reset in_ready", 32'(in_ready), 32'd1);

    // Zero with out_ready held high: single-cycle pulse
    out_ready = 1'b1;
    in_valid = 1'b1;
    bin = '0;
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("zero latency", 32'(lat), 32'd12);
    check("zero bcd", 32'(bcd), 32'h0000);
    tick();
    check("zero pulse", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Boundary and typical values
    convert(4095, 0, "max");
    convert(1234, 0, "1234");

    // in_valid held with 999 during conversion of 42
    in_valid = 1'b1;
    bin = WIDTH'(42);
    tick();
    bin = WIDTH'(999);
    lat = 0;
    bad = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) bad++;
      tick();
      lat++;
    end
    check("42 in_ready low", 32'(bad), 32'd0);
    check("42 latency", 32'(lat), 32'd12);
    check("42 bcd", 32'(bcd), 32'h0042);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("42 not reaccepted", 32'(in_ready), 32'd1);
    check("42 valid drop", 32'(out_valid), 32'd0);
    check("42 bcd kept", 32'(bcd), 32'h0042);
    tick();
    in_valid = 1'b0;
    check("999 accepted", 32'(in_ready), 32'd0);
    wait_valid(lat);
    check("999 latency", 32'(lat), 32'd12);
    check("999 bcd", 32'(bcd), 32'h0999);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Long stall on 777
    convert(777, 20, "stall777");

    // Reset at the 6th shift edge of 3000, with in_valid also high
    in_valid = 1'b1;
    bin = WIDTH'(3000);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    in_valid = 1'b1;
    tick();
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort bcd", 32'(bcd), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    hi = 0;
    repeat (20) begin
      tick();
      if (out_valid) hi++;
    end
    check("abort no result", 32'(hi), 32'd0);
    check("abort idle", 32'(in_ready), 32'd1);

    // Random values with random downstream stalls
    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(0, 4095));
      convert(v, int'($urandom_range(0, 3)), "random");
    end

`ifdef BIN2BCD_SEVSEG_EN
    // Segment decode of 80
    in_valid = 1'b1;
    bin = WIDTH'(80);
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("seg d0", 32'(seg[6:0]), 32'b1000000);
    check("seg d1", 32'(seg[13:7]), 32'b0000000);
    check("seg d2", 32'(seg[20:14]), 32'b1000000);
    check("seg d3", 32'(seg[27:21]), 32'b1000000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
